align_sequencer: RTL
====================

// Module: align_sequencer
// PURPOSE
//  Job-level controller for the ALIGN stage. Accepts job descriptors (num_iters, num_reads_per_iter).
//  For each job: issues the one-cycle ALIGN configure pulse, then gates ALIGN's downstream avail_in.
//  Mirrors ALIGN's iteration/read counters on ALIGN valid_out beats and pulses job_done after the
//  last beat. Sits between the layer control FSM and ALIGN; one job in flight plus one pending.
// PARAMETERS
//  LOG_MAX_ITERS          16  width of num_iters fields (must match ALIGN)
//  LOG_MAX_READS_PER_ITER 16  width of num_reads_per_iter fields (must match ALIGN)
//  LOG_MAX_JOBS           16  width of jobs_completed counter
// PORTS
//  clk                     in   1      clock, rising edge
//  rst                     in   1      asynchronous, active-low reset
//  cmd_valid               in   1      job descriptor valid
//  cmd_num_iters           in   LOG_MAX_ITERS           job iterations
//  cmd_num_reads_per_iter  in   LOG_MAX_READS_PER_ITER  job reads per iteration
//  cmd_avail               out  1      pending slot free; accept = cmd_valid & cmd_avail
//  align_configure         out  1      to ALIGN configure
//  align_num_iters         out  LOG_MAX_ITERS           to ALIGN num_iters
//  align_num_reads_per_iter out LOG_MAX_READS_PER_ITER  to ALIGN num_reads_per_iter
//  align_valid_out         in   1      from ALIGN valid_out (one beat = one ALIGN read)
//  align_avail_in          out  1      to ALIGN avail_in (gated downstream avail)
//  down_avail_in           in   1      downstream consumer avail
//  pause                   in   1      host stall request; holds beats while high
//  busy                    out  1      state != IDLE or pending slot full
//  job_done                out  1      one-cycle pulse after last beat of a job
//  job_err                 out  1      sticky: zero-field job or beat outside RUN
//  jobs_completed          out  LOG_MAX_JOBS            count of finished jobs, wraps
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, slot empty, counters 0, all outputs 0 except cmd_avail=1.
//  - Pending slot: one register. cmd_avail = ~slot_valid. Loaded on accept, freed on CONFIG entry.
//  - Zero-field job (iters==0 or reads==0): accepted, never stored, job_err set, job_done pulsed next
//    cycle, jobs_completed unchanged. No ALIGN configure is issued.
//  - FSM (registered state; align_configure, job_done are registered decodes):
//    IDLE   : slot_valid -> CONFIG
//    CONFIG : align_configure=1 exactly this cycle; align_num_* driven from slot (held until next
//             CONFIG); load iter_cnt=iters, rd_cnt=reads, rd_reload=reads; free slot -> RUN
//    RUN    : beat = align_valid_out. rd_cnt==1 & iter_cnt==1 on beat -> DONE;
//             rd_cnt==1 on beat -> iter_cnt-1, rd_cnt=rd_reload; else rd_cnt-1 on beat
//    DONE   : job_done=1, jobs_completed+1 (wraps at 2^LOG_MAX_JOBS) -> IDLE
//  - Latency: accept at edge t -> align_configure high in cycle t+2; first beat can arrive at t+3.
//    Back-to-back jobs: last beat at cycle b -> job_done b+1, configure b+3.
//  - align_avail_in = down_avail_in & ~pause & (state==RUN) (combinational; the only comb. path).
//  - align_valid_out high while state!=RUN: ignored for counting, job_err set.
//  - Accept during RUN/DONE allowed (fills slot); accept while slot full is impossible (cmd_avail=0).
//  - Accept in the same cycle as CONFIG frees the slot: not allowed; cmd_avail is the registered
//    ~slot_valid, so the new job loads at the following edge.
//  - pause high mid-job: beats stop, counters hold, state stays RUN; release resumes without loss.
//  - Counters never underflow: decrements only on beats in RUN with count > 1.
//  - rst low mid-job: immediate return to reset values. ALIGN must share the same rst.
// CONFIGURATION
//  ALIGN_SEQ_PERF_EN defined: adds outputs perf_run_cycles and perf_stall_cycles (32b each).
//    run_cycles increments every RUN cycle; stall_cycles increments on RUN cycles with no beat.
//    Both clear on reset only and saturate at all-ones.
//  Not defined: ports and logic absent; all other behaviour identical.
// TESTING
//  1 iters=2, reads=3, down_avail=1 -> configure 1 cycle at t+2, 6 beats, job_done 1 cycle after
//    6th beat, jobs_completed=1.
//  2 Two jobs (1,4) then (3,1) sent back-to-back -> second accepted during RUN of first, configure
//    3 cycles after first's last beat, jobs_completed=2.
//  3 iters=0, reads=5 -> no align_configure, job_err=1, job_done pulse, jobs_completed=0.
//  4 iters=1, reads=8, pause high after 3rd beat for 10 cycles -> align_avail_in=0 during pause,
//    exactly 8 beats total, job_done once.
//  5 Force align_valid_out=1 in IDLE -> job_err=1, jobs_completed unchanged.
//  6 rst low after 2 of 6 beats -> outputs at reset values immediately; new job (1,2) completes.
//  7 (ALIGN_SEQ_PERF_EN) iters=1, reads=4, down_avail toggling 1,0 -> perf_run_cycles=8,
//    perf_stall_cycles=4.

Source files
------------

// File: rtl/align_sequencer.sv
// Job-level controller for the ALIGN stage: queues one pending job, configures ALIGN and tracks its beats.
// Optional ALIGN_SEQ_PERF_EN adds saturating RUN/stall cycle counters (perf_run_cycles, perf_stall_cycles).
module align_sequencer #(
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_JOBS           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  input  logic [LOG_MAX_ITERS-1:0]          cmd_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] cmd_num_reads_per_iter,
  output logic                              cmd_avail,
  output logic                              align_configure,
  output logic [LOG_MAX_ITERS-1:0]          align_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] align_num_reads_per_iter,
  input  logic                              align_valid_out,
  output logic                              align_avail_in,
  input  logic                              down_avail_in,
  input  logic                              pause,
  output logic                              busy,
  output logic                              job_done,
  output logic                              job_err,
  output logic [LOG_MAX_JOBS-1:0]           jobs_completed
`ifdef ALIGN_SEQ_PERF_EN
  ,
  output logic [31:0]                       perf_run_cycles,
  output logic [31:0]                       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE = LOG_MAX_ITERS'(1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] RD_ONE   = LOG_MAX_READS_PER_ITER'(1);

  state_t                              state_q, state_d;
  logic                                slot_valid_q, slot_valid_d;
  logic [LOG_MAX_ITERS-1:0]            slot_iters_q, slot_iters_d;
  logic [LOG_MAX_READS_PER_ITER-1:0]   slot_reads_q, slot_reads_d;
  logic [LOG_MAX_ITERS-1:0]            iters_out_q, iters_out_d;
  logic [LOG_MAX_READS_PER_ITER-1:0]   reads_out_q, reads_out_d;
  logic [LOG_MAX_ITERS-1:0]            iter_cnt_q, iter_cnt_d;
  logic [LOG_MAX_READS_PER_ITER-1:0]   rd_cnt_q, rd_cnt_d;
  logic [LOG_MAX_READS_PER_ITER-1:0]   rd_reload_q, rd_reload_d;
  logic                                configure_q, configure_d;
  logic                                done_q, done_d;
  logic                                err_q, err_d;
  logic [LOG_MAX_JOBS-1:0]             jobs_q, jobs_d;

  logic accept;
  logic zero_job;
  logic store_job;
  logic in_run;
  logic beat;
  logic stray_beat;

  assign accept     = cmd_valid & ~slot_valid_q;
  assign zero_job   = accept & ((cmd_num_iters == '0) | (cmd_num_reads_per_iter == '0));
  assign store_job  = accept & ~zero_job;
  assign in_run     = (state_q == S_RUN);
  assign beat       = align_valid_out & in_run;
  assign stray_beat = align_valid_out & ~in_run;

  // Next-state and datapath updates; the slot is freed on the edge that enters CONFIG,
  // so a new job can only land one edge later (cmd_avail is registered).
  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    slot_iters_d = slot_iters_q;
    slot_reads_d = slot_reads_q;
    iters_out_d  = iters_out_q;
    reads_out_d  = reads_out_q;
    iter_cnt_d   = iter_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_reload_d  = rd_reload_q;

    if (store_job) begin
      slot_valid_d = 1'b1;
      slot_iters_d = cmd_num_iters;
      slot_reads_d = cmd_num_reads_per_iter;
    end

    case (state_q)
      S_IDLE: begin
        if (slot_valid_q) begin
          state_d      = S_CONFIG;
          slot_valid_d = 1'b0;
          iters_out_d  = slot_iters_q;
          reads_out_d  = slot_reads_q;
          iter_cnt_d   = slot_iters_q;
          rd_cnt_d     = slot_reads_q;
          rd_reload_d  = slot_reads_q;
        end
      end
      S_CONFIG: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (beat) begin
          if (rd_cnt_q == RD_ONE) begin
            if (iter_cnt_q <= ITER_ONE) begin
              state_d = S_DONE;
            end else begin
              iter_cnt_d = iter_cnt_q - ITER_ONE;
              rd_cnt_d   = rd_reload_q;
            end
          end else if (rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - RD_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered decodes of the next state keep configure/job_done glitch-free.
  always_comb begin
    configure_d = (state_d == S_CONFIG);
    done_d      = (state_d == S_DONE) | zero_job;
    err_d       = err_q | zero_job | stray_beat;
    jobs_d      = jobs_q;
    if (state_d == S_DONE) begin
      jobs_d = jobs_q + LOG_MAX_JOBS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      slot_valid_q <= 1'b0;
      slot_iters_q <= '0;
      slot_reads_q <= '0;
      iters_out_q  <= '0;
      reads_out_q  <= '0;
      iter_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      rd_reload_q  <= '0;
      configure_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      jobs_q       <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_iters_q <= slot_iters_d;
      slot_reads_q <= slot_reads_d;
      iters_out_q  <= iters_out_d;
      reads_out_q  <= reads_out_d;
      iter_cnt_q   <= iter_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_reload_q  <= rd_reload_d;
      configure_q  <= configure_d;
      done_q       <= done_d;
      err_q        <= err_d;
      jobs_q       <= jobs_d;
    end
  end

`ifdef ALIGN_SEQ_PERF_EN
  logic [31:0] perf_run_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_run_q   <= '0;
      perf_stall_q <= '0;
    end else if (in_run) begin
      if (perf_run_q != '1) begin
        perf_run_q <= perf_run_q + 32'd1;
      end
      if (!beat && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_run_cycles   = perf_run_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

  assign cmd_avail                = ~slot_valid_q;
  assign busy                     = (state_q != S_IDLE) | slot_valid_q;
  assign align_configure          = configure_q;
  assign align_num_iters          = iters_out_q;
  assign align_num_reads_per_iter = reads_out_q;
  // Only combinational path through the block: downstream backpressure into ALIGN.
  assign align_avail_in           = down_avail_in & ~pause & in_run;
  assign job_done                 = done_q;
  assign job_err                  = err_q;
  assign jobs_completed           = jobs_q;

endmodule
